// File: rtl/pll_rst_seq.sv
// Lock monitor and reset sequencer for the core PLL: pulses pll_rst, qualifies lock, releases core_rst.
// Build option: define PLL_MON_AUTORECOVER_EN to re-run the sequence on a RUN lock loss instead of faulting.
module pll_rst_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int LOCK_STABLE    = 1024,
    parameter int CORE_RST_HOLD  = 64,
    parameter int MAX_RETRIES    = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             core_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int RC_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int TO_W = (LOCK_TIMEOUT > 1)   ? $clog2(LOCK_TIMEOUT)   : 1;
    localparam int LS_W = (LOCK_STABLE > 1)    ? $clog2(LOCK_STABLE)    : 1;
    localparam int HD_W = (CORE_RST_HOLD > 1)  ? $clog2(CORE_RST_HOLD)  : 1;
    localparam int RT_W = $clog2(MAX_RETRIES + 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;
    logic [2:0]             state_r, state_s;
    logic [RC_W-1:0]        rst_cnt_r, rst_cnt_s;
    logic [TO_W-1:0]        to_cnt_r, to_cnt_s;
    logic [LS_W-1:0]        stab_cnt_r, stab_cnt_s;
    logic [HD_W-1:0]        hold_cnt_r, hold_cnt_s;
    logic [RT_W-1:0]        retry_r, retry_s, retry_inc_s;
    logic [CNT_W-1:0]       loss_cnt_r, loss_cnt_s;
    logic                   pll_rst_r, core_rst_r, ready_r, fault_r;

    assign locked_s      = sync_r[SYNC_STAGES-1];
    assign retry_inc_s   = retry_r + RT_W'(1);
    assign pll_rst       = pll_rst_r;
    assign core_rst      = core_rst_r;
    assign ready         = ready_r;
    assign fault         = fault_r;
    assign lock_loss_cnt = loss_cnt_r;

    // Metastability synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge clk) begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
    end

    // Next-state and counter update; every counter is cleared whenever its state is left
    always_comb begin
        state_s    = state_r;
        rst_cnt_s  = '0;
        to_cnt_s   = '0;
        stab_cnt_s = '0;
        hold_cnt_s = '0;
        retry_s    = retry_r;
        loss_cnt_s = loss_cnt_r;
        case (state_r)
            ST_PLL_RST: begin
                if (rst_cnt_r == RC_W'(PLL_RST_CYCLES - 1)) begin
                    state_s = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_s = rst_cnt_r + RC_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the terminal count still wins over the retry
                if (locked_s) begin
                    state_s = ST_STABLE;
                end else if (to_cnt_r == TO_W'(LOCK_TIMEOUT - 1)) begin
                    retry_s = retry_inc_s;
                    if (retry_inc_s == RT_W'(MAX_RETRIES)) begin
                        state_s = ST_FAULT;
                    end else begin
                        state_s = ST_PLL_RST;
                    end
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_s = ST_WAIT_LOCK;
                end else if (stab_cnt_r == LS_W'(LOCK_STABLE - 1)) begin
                    state_s = ST_HOLD;
                end else begin
                    stab_cnt_s = stab_cnt_r + LS_W'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_s = ST_WAIT_LOCK;
                end else if (hold_cnt_r == HD_W'(CORE_RST_HOLD - 1)) begin
                    state_s = ST_RUN;
                    retry_s = '0;
                end else begin
                    hold_cnt_s = hold_cnt_r + HD_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    if (loss_cnt_r != {CNT_W{1'b1}}) begin
                        loss_cnt_s = loss_cnt_r + CNT_W'(1);
                    end else begin
                        loss_cnt_s = loss_cnt_r;
                    end
`ifdef PLL_MON_AUTORECOVER_EN
                    state_s = ST_PLL_RST;
                    retry_s = '0;
`else
                    state_s = ST_FAULT;
`endif
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                state_s = ST_FAULT;
            end
            default: begin
                state_s = ST_FAULT;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so they track state_r
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_PLL_RST;
            rst_cnt_r  <= '0;
            to_cnt_r   <= '0;
            stab_cnt_r <= '0;
            hold_cnt_r <= '0;
            retry_r    <= '0;
            loss_cnt_r <= '0;
            pll_rst_r  <= 1'b1;
            core_rst_r <= 1'b1;
            ready_r    <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            rst_cnt_r  <= rst_cnt_s;
            to_cnt_r   <= to_cnt_s;
            stab_cnt_r <= stab_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            retry_r    <= retry_s;
            loss_cnt_r <= loss_cnt_s;
            pll_rst_r  <= (state_s == ST_PLL_RST) || (state_s == ST_FAULT);
            core_rst_r <= (state_s != ST_RUN);
            ready_r    <= (state_s == ST_RUN);
            fault_r    <= (state_s == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: phase/timestamp reference model checked every cycle, plus hand-timed directed checks.
module tb_pll_rst_seq;

    localparam int T_PRST = 3;
    localparam int T_TO   = 50;
    localparam int T_STAB = 8;
    localparam int T_HOLD = 4;
    localparam int MAXR   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b1;
    logic       pll_rst, core_rst, ready, fault;
    logic [7:0] lock_loss_cnt;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    pll_rst_seq #(
        .SYNC_STAGES(2), .PLL_RST_CYCLES(T_PRST), .LOCK_TIMEOUT(T_TO),
        .LOCK_STABLE(T_STAB), .CORE_RST_HOLD(T_HOLD), .MAX_RETRIES(MAXR), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
        .core_rst(core_rst), .ready(ready), .fault(fault), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Reference model: phases with entry timestamps; a phase of length d is left on its d-th edge
    localparam int PH_PRST = 0, PH_WAIT = 1, PH_STAB = 2, PH_HOLD = 3, PH_RUN = 4, PH_FAULT = 5;
    int     m_phase = PH_PRST;
    int     m_enter = 0;
    int     m_now   = 0;
    int     m_retry = 0;
    int     m_loss  = 0;
    bit [1:0] m_hist = 2'b00;

    task automatic enter(input int p);
        m_phase = p;
        m_enter = m_now;
    endtask

    always @(posedge clk) begin
        bit ls;
        int el;
        m_now++;
        ls     = m_hist[1];
        m_hist = {m_hist[0], pll_locked};
        el     = m_now - m_enter;
        if (rst) begin
            enter(PH_PRST);
            m_retry = 0;
            m_loss  = 0;
        end else begin
            case (m_phase)
                PH_PRST: if (el >= T_PRST) enter(PH_WAIT);
                PH_WAIT: begin
                    if (ls) enter(PH_STAB);
                    else if (el >= T_TO) begin
                        m_retry++;
                        enter((m_retry == MAXR) ? PH_FAULT : PH_PRST);
                    end
                end
                PH_STAB: begin
                    if (!ls) enter(PH_WAIT);
                    else if (el >= T_STAB) enter(PH_HOLD);
                end
                PH_HOLD: begin
                    if (!ls) enter(PH_WAIT);
                    else if (el >= T_HOLD) begin
                        enter(PH_RUN);
                        m_retry = 0;
                    end
                end
                PH_RUN: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
`ifdef PLL_MON_AUTORECOVER_EN
                        enter(PH_PRST);
                        m_retry = 0;
`else
                        enter(PH_FAULT);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        int exp_v;
        int act_v;
        if (cmp_en) begin
            exp_v = ((m_phase == PH_PRST || m_phase == PH_FAULT) ? 2048 : 0)
                  + ((m_phase != PH_RUN) ? 1024 : 0)
                  + ((m_phase == PH_RUN) ? 512 : 0)
                  + ((m_phase == PH_FAULT) ? 256 : 0) + m_loss;
            act_v = {20'd0, pll_rst, core_rst, ready, fault, lock_loss_cnt};
            chk("model_outputs", act_v, exp_v);
        end
    end

    // Sample record indexed by negedge since the last start_rec
    bit pr_a[256], cr_a[256], rd_a[256], ft_a[256];
    int lc_a[256];
    int idx = 0;

    task automatic samp();
        if (idx < 256) begin
            pr_a[idx] = pll_rst;
            cr_a[idx] = core_rst;
            rd_a[idx] = ready;
            ft_a[idx] = fault;
            lc_a[idx] = int'(lock_loss_cnt);
        end
    endtask

    task automatic start_rec();
        idx = 0;
        samp();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            idx++;
            samp();
        end
    endtask

    function automatic int first_at(input int which, input bit val, input int from);
        for (int i = from; i < 256; i++) begin
            bit v;
            case (which)
                0: v = pr_a[i];
                1: v = rd_a[i];
                default: v = ft_a[i];
            endcase
            if (v == val) return i;
        end
        return -1;
    endfunction

    task automatic wait_ready(input int budget);
        int k;
        k = 0;
        while (!ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_reset(input bit lk);
        rst = 1'b1;
        pll_locked = lk;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        start_rec();
    endtask

    initial begin
        // Test 1: reset values, then locked from the start
        rst = 1'b1;
        pll_locked = 1'b1;
        repeat (4) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_core_rst", int'(core_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_cnt", int'(lock_loss_cnt), 0);
        rst = 1'b0;
        start_rec();
        step(20);
        chk("t1_pll_rst_fall", first_at(0, 1'b0, 0), 3);
        chk("t1_ready_rise", first_at(1, 1'b1, 0), 16);
        chk("t1_core_rst_run", int'(cr_a[16]), 0);

        // Test 4: lock lost in RUN for 3 cycles
        pll_locked = 1'b0;
        start_rec();
        step(3);
        pll_locked = 1'b1;
        step(25);
        chk("t4_ready_before", int'(rd_a[2]), 1);
        chk("t4_ready_drop", int'(rd_a[3]), 0);
        chk("t4_core_rst", int'(cr_a[3]), 1);
        chk("t4_loss_cnt", lc_a[3], 1);
        chk("t4_pll_rst", int'(pr_a[3]), 1);
`ifdef PLL_MON_AUTORECOVER_EN
        chk("t4_pll_rst_fall", first_at(0, 1'b0, 3), 6);
        chk("t4_ready_again", first_at(1, 1'b1, 3), 19);
        // Test 5: saturate the lock-loss counter
        for (int n = 0; n < 257; n++) begin
            pll_locked = 1'b0;
            repeat (3) @(negedge clk);
            pll_locked = 1'b1;
            wait_ready(60);
        end
        chk("t5_loss_sat", int'(lock_loss_cnt), 255);
`else
        chk("t4_fault", int'(ft_a[3]), 1);
        chk("t4_fault_sticky", int'(ft_a[28]), 1);
        chk("t4_core_rst_sticky", int'(cr_a[28]), 1);
`endif

        // Test 2: never locks -> two pll_rst pulses then FAULT
        do_reset(1'b0);
        step(120);
        chk("t2_loss_cleared", lc_a[0], 0);
        chk("t2_pulse1_end", first_at(0, 1'b0, 0), 3);
        chk("t2_pulse2_start", first_at(0, 1'b1, 3), 53);
        chk("t2_pulse2_end", first_at(0, 1'b0, 53), 56);
        chk("t2_fault_rise", first_at(2, 1'b1, 0), 106);
        chk("t2_fault_hold", int'(ft_a[120]), 1);
        chk("t2_pll_rst_hold", int'(pr_a[120]), 1);
        chk("t2_core_rst_hold", int'(cr_a[120]), 1);

        // Test 3: one-cycle lock glitch during STABLE
        do_reset(1'b0);
        step(5);
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(25);
        chk("t3_ready_rise", first_at(1, 1'b1, 0), 26);
        chk("t3_no_retry", int'(pr_a[20]), 0);

        // Test 6: one-cycle rst during HOLD
        do_reset(1'b1);
        step(13);
        chk("t6_in_hold", int'(cr_a[13]) * 2 + int'(pr_a[13]), 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_rst_pll_rst", int'(pr_a[14]), 1);
        chk("t6_rst_ready", int'(rd_a[14]), 0);
        chk("t6_rst_cnt", lc_a[14], 0);
        step(20);
        chk("t6_pll_rst_fall", first_at(0, 1'b0, 14), 17);
        chk("t6_ready_rise", first_at(1, 1'b1, 14), 30);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
